// File: rtl/dmem_lsu.sv
// Load/store unit for the MIPS16 memory stage: req/ack data-memory port with pipeline stall.
// Define LSU_TIMEOUT_EN to abort a request that receives no mem_ack within TIMEOUT cycles.
module dmem_lsu #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 16
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [15:0]       ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              lsu_stall,
  output logic [DATA_W-1:0] mem_out,
  output logic              mem_out_valid,
  output logic              align_err,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   mem_out_q, mem_out_d;
  logic                mem_out_valid_q, mem_out_valid_d;
  logic                align_err_q, align_err_d;
  logic                access_c;
  logic                stall_c;
  logic                unused_addr_hi;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = 10;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                bus_err_q, bus_err_d;
`endif

  assign access_c       = ex_valid & (ex_load | ex_store);
  assign unused_addr_hi = ^ex_addr[15:ADDR_W+1];

  // Next-state and output decode
  always_comb begin
    state_d         = state_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_out_d       = mem_out_q;
    mem_out_valid_d = 1'b0;
    align_err_d     = 1'b0;
    stall_c         = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d           = cnt_q;
    bus_err_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (access_c) begin
          if (ex_addr[0]) begin
            align_err_d = 1'b1;
          end else begin
            state_d     = ST_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = ex_store & ~ex_load;
            mem_addr_d  = ex_addr[ADDR_W:1];
            mem_wdata_d = ex_wdata;
            stall_c     = 1'b1;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        if (mem_ack) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            mem_out_d       = mem_rdata;
            mem_out_valid_d = 1'b1;
          end
        end
`ifdef LSU_TIMEOUT_EN
        // An ack arriving on the final allowed cycle takes priority over the abort
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_out_q       <= '0;
      mem_out_valid_q <= 1'b0;
      align_err_q     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q           <= '0;
      bus_err_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_out_q       <= mem_out_d;
      mem_out_valid_q <= mem_out_valid_d;
      align_err_q     <= align_err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q           <= cnt_d;
      bus_err_q       <= bus_err_d;
`endif
    end
  end

  // Stall is decoded combinationally so the accepting cycle already freezes the pipeline
  assign lsu_stall     = rst_n & stall_c;
  assign mem_out       = mem_out_q;
  assign mem_out_valid = mem_out_valid_q;
  assign align_err     = align_err_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
`ifdef LSU_TIMEOUT_EN
  assign bus_err       = bus_err_q;
`else
  assign bus_err       = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed scenarios plus randomized accesses
// checked against a transaction-level model (latency, address mapping, load data).
module tb_dmem_lsu;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 16;
`ifdef LSU_TIMEOUT_EN
  localparam int MAX_DLY = 3;
`else
  localparam int MAX_DLY = 5;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0;
  logic [15:0]       ex_addr = '0;
  logic [DATA_W-1:0] ex_wdata = '0;
  logic              lsu_stall, mem_out_valid, align_err, bus_err, mem_req, mem_we;
  logic [DATA_W-1:0] mem_out, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] exp_out = '0;

  always #5 clk = ~clk;

  dmem_lsu #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
`ifdef LSU_TIMEOUT_EN
    ,
    .TIMEOUT(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .lsu_stall(lsu_stall), .mem_out(mem_out), .mem_out_valid(mem_out_valid),
    .align_err(align_err), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Present one instruction and act as memory; ack on the (ack_dly+1)-th request cycle.
  // Ends after the cycle in which lsu_stall is low (the instruction advances there).
  task automatic run_access(input logic ld, input logic st, input logic [15:0] addr,
                            input logic [15:0] wd, input int ack_dly, input logic [15:0] rd,
                            input int max_cyc, output int stall_n, output int req_n,
                            output int valid_n, output int align_n, output int berr_n,
                            output int bad_hold, output logic ended);
    logic [12:0] exp_a;
    logic        exp_we;
    exp_a = addr[13:1];
    exp_we = st & ~ld;
    stall_n = 0; req_n = 0; valid_n = 0; align_n = 0; berr_n = 0; bad_hold = 0; ended = 1'b0;
    for (int c = 0; c < max_cyc && !ended; c++) begin
      @(negedge clk);
      if (c == 0) begin
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_addr = addr; ex_wdata = wd;
      end
      mem_ack = mem_req && (req_n == ack_dly);
      mem_rdata = mem_ack ? rd : 16'($urandom);
      if (mem_req) begin
        if (mem_addr !== exp_a || mem_we !== exp_we || mem_wdata !== wd) bad_hold++;
        req_n++;
      end
      #1;
      if (lsu_stall) stall_n++; else ended = 1'b1;
      if (mem_out_valid) valid_n++;
      if (align_err) align_n++;
      if (bus_err) berr_n++;
    end
  endtask

  // Cycles with no valid instruction; optionally drives a spurious ack
  task automatic run_idle(input int n, input logic spur, output int req_n, output int valid_n,
                          output int align_n, output int stall_n);
    req_n = 0; valid_n = 0; align_n = 0; stall_n = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      ex_valid = 1'b0; ex_load = 1'($urandom); ex_store = 1'($urandom);
      ex_addr = 16'($urandom);
      mem_ack = spur;
      mem_rdata = 16'($urandom);
      #1;
      if (mem_req) req_n++;
      if (mem_out_valid) valid_n++;
      if (align_err) align_n++;
      if (lsu_stall) stall_n++;
    end
  endtask

  task automatic test_reset();
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_addr = 16'h0024;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_cmp++; if ({mem_req, mem_we, mem_out_valid, align_err, bus_err, lsu_stall} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {mem_req, mem_we, mem_out_valid, align_err, bus_err, lsu_stall}); end
      n_cmp++; if ({mem_addr, mem_wdata, mem_out} !== 45'b0) begin n_fail++; $display("FAIL reset_data: addr %h wdata %h out %h want 0", mem_addr, mem_wdata, mem_out); end
    end
    ex_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    exp_out = 16'h0000;
  endtask

  task automatic test_load_imm();
    int s, r, v, a, b, h; logic e;
    run_access(1'b1, 1'b0, 16'h0024, 16'h5555, 0, 16'hBEEF, 10, s, r, v, a, b, h, e);
    exp_out = 16'hBEEF;
    n_cmp++; if (s !== 2 || !e) begin n_fail++; $display("FAIL load_stall: got %0d ended %0b want 2", s, e); end
    n_cmp++; if (r !== 1 || h !== 0) begin n_fail++; $display("FAIL load_req: req %0d bad_addr_we %0d want 1/0", r, h); end
    n_cmp++; if (v !== 1 || mem_out !== exp_out) begin n_fail++; $display("FAIL load_data: valid %0d out %h want 1/%h", v, mem_out, exp_out); end
  endtask

  task automatic test_store_delayed();
    int s, r, v, a, b, h; logic e;
    run_access(1'b0, 1'b1, 16'h1FFE, 16'h1234, 3, 16'hA5A5, 20, s, r, v, a, b, h, e);
    n_cmp++; if (s !== 5 || !e) begin n_fail++; $display("FAIL store_stall: got %0d want 5", s); end
    n_cmp++; if (r !== 4 || h !== 0) begin n_fail++; $display("FAIL store_req: req %0d bad_hold %0d want 4/0", r, h); end
    n_cmp++; if (v !== 0 || mem_out !== exp_out) begin n_fail++; $display("FAIL store_out: valid %0d out %h want 0/%h", v, mem_out, exp_out); end
  endtask

  task automatic test_misaligned();
    int s, r, v, a, b, h; logic e;
    int ir, iv, ia, is;
    run_access(1'b1, 1'b0, 16'h0003, 16'h0000, 0, 16'h7777, 5, s, r, v, a, b, h, e);
    n_cmp++; if (s !== 0 || r !== 0 || a !== 0) begin n_fail++; $display("FAIL misalign_accept: stall %0d req %0d align %0d want 0/0/0", s, r, a); end
    run_idle(1, 1'b0, ir, iv, ia, is);
    n_cmp++; if (ia !== 1 || ir !== 0) begin n_fail++; $display("FAIL misalign_pulse: align %0d req %0d want 1/0", ia, ir); end
    run_idle(2, 1'b0, ir, iv, ia, is);
    n_cmp++; if (ia !== 0 || ir !== 0 || mem_out !== exp_out) begin n_fail++; $display("FAIL misalign_after: align %0d req %0d out %h want 0/0/%h", ia, ir, mem_out, exp_out); end
  endtask

  task automatic test_back_to_back();
    int s, r, v, a, b, h; logic e;
    int ir, iv, ia, is;
    run_access(1'b1, 1'b0, 16'h0040, 16'h0, 0, 16'h0001, 10, s, r, v, a, b, h, e);
    n_cmp++; if (s !== 2 || v !== 1 || mem_out !== 16'h0001) begin n_fail++; $display("FAIL b2b_first: stall %0d valid %0d out %h want 2/1/0001", s, v, mem_out); end
    run_access(1'b1, 1'b0, 16'h0042, 16'h0, 0, 16'h0002, 10, s, r, v, a, b, h, e);
    exp_out = 16'h0002;
    n_cmp++; if (s !== 2 || r !== 1 || h !== 0) begin n_fail++; $display("FAIL b2b_second_timing: stall %0d req %0d bad %0d want 2/1/0", s, r, h); end
    n_cmp++; if (v !== 1 || mem_out !== exp_out) begin n_fail++; $display("FAIL b2b_second_data: valid %0d out %h want 1/%h", v, mem_out, exp_out); end
    run_idle(3, 1'b1, ir, iv, ia, is);
    n_cmp++; if (ir !== 0 || iv !== 0 || mem_out !== exp_out) begin n_fail++; $display("FAIL spurious_ack: req %0d valid %0d out %h want 0/0/%h", ir, iv, mem_out, exp_out); end
  endtask

  task automatic test_reset_mid();
    int s, r, v, a, b, h; logic e;
    logic [15:0] rd;
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_addr = 16'h0100; mem_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_before: got %b want 1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({mem_req, mem_we, mem_out_valid, align_err, bus_err, lsu_stall} !== 6'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got %b want 000000", {mem_req, mem_we, mem_out_valid, align_err, bus_err, lsu_stall}); end
    n_cmp++; if ({mem_addr, mem_wdata, mem_out} !== 45'b0) begin n_fail++; $display("FAIL rstmid_data: addr %h wdata %h out %h want 0", mem_addr, mem_wdata, mem_out); end
    exp_out = 16'h0000;
    @(negedge clk);
    ex_valid = 1'b0; rst_n = 1'b1;
    rd = 16'($urandom);
    run_access(1'b1, 1'b0, 16'h0100, 16'h0, 1, rd, 10, s, r, v, a, b, h, e);
    exp_out = rd;
    n_cmp++; if (s !== 3 || r !== 2 || v !== 1 || mem_out !== exp_out) begin n_fail++; $display("FAIL rstmid_reload: stall %0d req %0d valid %0d out %h want 3/2/1/%h", s, r, v, mem_out, exp_out); end
  endtask

  task automatic test_random();
    int s, r, v, a, b, h; logic e;
    int ir, iv, ia, is;
    int kind, dly, gap;
    logic ld, st, mis;
    logic [15:0] addr, wd, rd;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      ld = (kind < 4) || (kind == 7) || (kind == 8);
      st = (kind >= 4 && kind <= 7) || (kind == 9);
      mis = (kind >= 8);
      addr = 16'($urandom);
      addr[0] = mis;
      wd = 16'($urandom);
      rd = 16'($urandom);
      dly = $urandom_range(0, MAX_DLY);
      run_access(ld, st, addr, wd, dly, rd, 20, s, r, v, a, b, h, e);
      if (!mis && ld) exp_out = rd;
      n_cmp++; if (s !== (mis ? 0 : dly + 2) || !e) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, s, mis ? 0 : dly + 2); end
      n_cmp++; if (r !== (mis ? 0 : dly + 1) || h !== 0) begin n_fail++; $display("FAIL rnd_req[%0d]: req %0d bad %0d want %0d/0", i, r, h, mis ? 0 : dly + 1); end
      n_cmp++; if (v !== ((!mis && ld) ? 1 : 0) || mem_out !== exp_out || b !== 0) begin n_fail++; $display("FAIL rnd_data[%0d]: valid %0d out %h berr %0d want %0d/%h/0", i, v, mem_out, b, (!mis && ld) ? 1 : 0, exp_out); end
      gap = mis ? $urandom_range(1, 2) : $urandom_range(0, 2);
      if (gap > 0) begin
        run_idle(gap, 1'($urandom), ir, iv, ia, is);
        n_cmp++; if (ia !== (mis ? 1 : 0) || ir !== 0 || iv !== 0) begin n_fail++; $display("FAIL rnd_gap[%0d]: align %0d req %0d valid %0d want %0d/0/0", i, ia, ir, iv, mis ? 1 : 0); end
      end
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int s, r, v, a, b, h; logic e;
    run_access(1'b1, 1'b0, 16'h0010, 16'h0, 0, 16'hBEEF, 10, s, r, v, a, b, h, e);
    exp_out = 16'hBEEF;
    run_access(1'b1, 1'b0, 16'h0020, 16'h0, 1000, 16'h1111, 20, s, r, v, a, b, h, e);
    n_cmp++; if (r !== 4 || s !== 5 || !e) begin n_fail++; $display("FAIL timeout_len: req %0d stall %0d want 4/5", r, s); end
    n_cmp++; if (b !== 1 || v !== 0 || mem_out !== exp_out) begin n_fail++; $display("FAIL timeout_resp: berr %0d valid %0d out %h want 1/0/%h", b, v, mem_out, exp_out); end
    run_access(1'b1, 1'b0, 16'h0030, 16'h0, 3, 16'h2222, 20, s, r, v, a, b, h, e);
    exp_out = 16'h2222;
    n_cmp++; if (b !== 0 || v !== 1 || r !== 4 || mem_out !== exp_out) begin n_fail++; $display("FAIL timeout_ack_wins: berr %0d valid %0d req %0d out %h want 0/1/4/%h", b, v, r, mem_out, exp_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_imm();
    test_store_delayed();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit for the MIPS16 memory stage. It turns EX-stage load/store requests into a req/ack transaction on the data-memory port and stalls the pipeline until the transaction completes. It returns load data on `mem_out`, the memory-data input to the writeback select. Word-addressed memory: 16-bit data, 13-bit word address.

## Interface
- `ADDR_W`, 13, data-memory word-address width.
- `DATA_W`, 16, data width.
- `TIMEOUT`, 255, cycles without `mem_ack` before abort (only with `LSU_TIMEOUT_EN`; range 1..1023).

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  EX-stage instruction valid.
- `ex_load`  in  1  instruction is a load.
- `ex_store`  in  1  instruction is a store (`ex_load` and `ex_store` both high is treated as a load).
- `ex_addr`  in  16  byte address (ALU result).
- `ex_wdata`  in  DATA_W  store data.
- `lsu_stall`  out  1  freeze IF/ID/EX; the pipeline holds all `ex_*` inputs stable while this is high.
- `mem_out`  out  DATA_W  last loaded word, registered.
- `mem_out_valid`  out  1  one-cycle pulse: `mem_out` updated by a completed load.
- `align_err`  out  1  one-cycle pulse: misaligned access rejected.
- `bus_err`  out  1  one-cycle pulse: transaction aborted by timeout.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write enable, qualified by `mem_req`.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_ack`  in  1  memory completion; read data valid in the same cycle.
- `mem_rdata`  in  DATA_W  read data.

## Operation
- An access is `ex_valid & (ex_load | ex_store)`.
- Misaligned means `ex_addr[0]=1`. Word address is `ex_addr[13:1]`; `ex_addr[15:14]` is ignored.
- FSM states IDLE, WAIT, RESP.
- IDLE, aligned access:
  - latch the address, `mem_we` (= store and not load) and write data;
  - next state WAIT;
  - `lsu_stall=1` combinationally in that cycle.
- IDLE, misaligned access:
  - no request; `align_err` pulses on the next cycle;
  - `lsu_stall=0`; `mem_out` unchanged; stay in IDLE.
- WAIT:
  - `mem_req=1`; address, `we` and `wdata` stay stable; `lsu_stall=1`.
  - On `mem_ack`, go to RESP and drop `mem_req` on that edge.
  - On `mem_ack` for a load, capture `mem_rdata` into `mem_out`.
- RESP, one cycle:
  - `lsu_stall=0`, so the instruction advances.
  - `mem_out_valid=1` if the access was a load.
  - No acceptance in RESP, because `ex_*` still shows the completed instruction. Next state IDLE.
- `mem_ack` outside WAIT is ignored.
- Stores never modify `mem_out`.
- `mem_out` holds its value until the next completed load.

## Timing
- Reset values:
  - state IDLE;
  - `mem_req`, `mem_we`, `mem_out_valid`, `align_err`, `bus_err` = 0;
  - `mem_addr`, `mem_wdata`, `mem_out` = 0.
  - `lsu_stall` is 0 while in reset.
- Reset mid-transaction: `mem_req` drops asynchronously; the access is lost. The pipeline reset restarts it.
- Cycle 0: access accepted in IDLE. Cycle 1: `mem_req` high (registered).
- Ack in cycle 1+k (k≥0) gives RESP in cycle 2+k. Minimum stall is 2 cycles; `mem_out_valid` appears at the earliest 2 cycles after acceptance.
- Back-to-back loads: the second is accepted in the cycle after RESP. Minimum 3 cycles per access.
- `align_err` pulses exactly 1 cycle, in the cycle after the misaligned access was presented.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A 10-bit counter clears on entry to WAIT and increments each WAIT cycle without `mem_ack`.
  - When it reaches `TIMEOUT`, `mem_req` drops and the FSM enters RESP with `bus_err=1` and `mem_out_valid=0`; `mem_out` is unchanged.
  - `mem_ack` in the same cycle the counter reaches `TIMEOUT` wins: normal completion, no `bus_err`.
- `LSU_TIMEOUT_EN` undefined:
  - WAIT lasts until `mem_ack`, indefinitely; `bus_err` is tied 0; no counter logic.

## Test plan
- Load at `ex_addr=16'h0024`, `mem_ack` returned in the same cycle `mem_req` rises, `mem_rdata=16'hBEEF`:
  - `mem_addr=13'h0012`, `mem_we=0`;
  - `lsu_stall` high exactly 2 cycles;
  - `mem_out=16'hBEEF` with `mem_out_valid` pulse in the RESP cycle.
- Store at `ex_addr=16'h1FFE`, `wdata=16'h1234`, ack delayed 3 cycles:
  - `mem_addr=13'h0FFF`, `mem_we=1`, `wdata` held stable for 4 request cycles;
  - `mem_out` unchanged; no `mem_out_valid`.
- Load at `ex_addr=16'h0003`:
  - `mem_req` never rises; `align_err` 1-cycle pulse; `lsu_stall` stays 0.
- Load, then load back-to-back (`rdata` `16'h0001` then `16'h0002`, immediate acks):
  - accesses complete 3 cycles apart; both values appear in order;
  - a spurious `mem_ack` in IDLE has no effect.
- `rst_n` asserted low while in WAIT:
  - `mem_req` falls without a clock edge; all outputs at reset values;
  - after release, a new load completes normally.
- With `LSU_TIMEOUT_EN`, `TIMEOUT=4`, no ack:
  - `mem_req` high 4 cycles, then `bus_err` pulse and `lsu_stall` low;
  - `mem_out` keeps its prior value `16'hBEEF`.
